conv_fifo_fill: RTL

Responder for the master controller's FIFO-fill command: on fill_enable it walks an input feature map in BRAM and scatters every KxK stride-1 convolution window, tap by tap, into the per-tap input FIFOs that feed the systolic array rows. It drives the image BRAM read port and the FIFO write enables. It raises fill_done when the whole map has been pushed and holds it until the master deasserts fill_reset.

---
 rtl/conv_fifo_fill.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_fifo_fill.sv
// FIFO-fill responder: walks a feature map in BRAM and scatters every KxK stride-1
// window, tap by tap, into the per-tap systolic-array input FIFOs.
module conv_fifo_fill #(
   parameter int unsigned array_size   = 9,
   parameter int unsigned data_size    = 16,
   parameter int unsigned dimdata_size = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fill_reset,
   input  logic                    fill_enable,
   input  logic [13:0]             initial_address,
   input  logic [dimdata_size-1:0] image_height,
   input  logic [dimdata_size-1:0] image_width,
   input  logic [3:0]              kernel_size,
   input  logic [7:0]              fifo_offset,
   output logic                    fill_done,
   output logic                    busy,
   output logic                    mem_en,
   output logic [13:0]             mem_addr,
   input  logic [data_size-1:0]    mem_rdata,
   output logic [array_size-1:0]   fifo_w_en,
   output logic [data_size-1:0]    fifo_w_data,
   input  logic [array_size-1:0]   fifo_full
);

   localparam int unsigned AW = 14;
   localparam int unsigned KW = 4;
   localparam int unsigned OW = 8;
   localparam int unsigned LW = 9;
   localparam int unsigned IW = (array_size > 1) ? $clog2(array_size) : 1;
   localparam logic [LW-1:0] LANES = LW'(array_size);

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PUSH, DONE} state_t;

   state_t                  state;
   logic [AW-1:0]           base;
   logic [dimdata_size-1:0] img_w;
   logic [dimdata_size-1:0] h_lim;
   logic [dimdata_size-1:0] w_lim;
   logic [KW-1:0]           k;
   logic [OW-1:0]           offset;
   logic [dimdata_size-1:0] r;
   logic [dimdata_size-1:0] c;
   logic [KW-1:0]           ky;
   logic [KW-1:0]           kx;
   logic [LW-1:0]           lane;

   logic [dimdata_size-1:0] nxt_r;
   logic [dimdata_size-1:0] nxt_c;
   logic [KW-1:0]           nxt_ky;
   logic [KW-1:0]           nxt_kx;
   logic [LW-1:0]           nxt_lane;
   logic [AW-1:0]           nxt_addr;
   logic [IW-1:0]           lane_idx;
   logic                    last_tap;
   logic                    lane_ok;
   logic                    push_ok;
   logic                    advance;
   logic                    degenerate;

   // Successor of the current tap in r/c/ky/kx order, and the lane/address it maps to.
   always_comb begin
      nxt_r    = r;
      nxt_c    = c;
      nxt_ky   = ky;
      nxt_kx   = kx;
      last_tap = 1'b0;
      if (kx != k - KW'(1)) begin
         nxt_kx = kx + KW'(1);
      end else begin
         nxt_kx = '0;
         if (ky != k - KW'(1)) begin
            nxt_ky = ky + KW'(1);
         end else begin
            nxt_ky = '0;
            if (c != w_lim) begin
               nxt_c = c + dimdata_size'(1);
            end else begin
               nxt_c = '0;
               if (r != h_lim) nxt_r = r + dimdata_size'(1);
               else            last_tap = 1'b1;
            end
         end
      end
      nxt_lane = LW'(offset) + LW'(nxt_ky) * LW'(k) + LW'(nxt_kx);
      nxt_addr = base + (AW'(nxt_r) + AW'(nxt_ky)) * AW'(img_w) + AW'(nxt_c) + AW'(nxt_kx);
   end

   // The write must be qualified by the full flag in the same cycle, so the enable is not registered.
   always_comb begin
      lane_ok    = (lane < LANES);
      lane_idx   = IW'(lane);
      push_ok    = (state == PUSH) && !fifo_full[lane_idx];
      advance    = ((state == ISSUE) && !lane_ok) || push_ok;
      fifo_w_en  = push_ok ? (array_size'(1) << lane_idx) : '0;
      degenerate = (kernel_size == '0) ||
                   (image_height < dimdata_size'(kernel_size)) ||
                   (image_width  < dimdata_size'(kernel_size));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fill_done   <= 1'b0;
         busy        <= 1'b0;
         mem_en      <= 1'b0;
         mem_addr    <= '0;
         fifo_w_data <= '0;
         base        <= '0;
         img_w       <= '0;
         h_lim       <= '0;
         w_lim       <= '0;
         k           <= '0;
         offset      <= '0;
         r           <= '0;
         c           <= '0;
         ky          <= '0;
         kx          <= '0;
         lane        <= '0;
      end else if (!fill_reset) begin
         state       <= IDLE;
         fill_done   <= 1'b0;
         busy        <= 1'b0;
         mem_en      <= 1'b0;
         mem_addr    <= '0;
         fifo_w_data <= '0;
         base        <= '0;
         img_w       <= '0;
         h_lim       <= '0;
         w_lim       <= '0;
         k           <= '0;
         offset      <= '0;
         r           <= '0;
         c           <= '0;
         ky          <= '0;
         kx          <= '0;
         lane        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fill_enable) begin
                  base   <= initial_address;
                  img_w  <= image_width;
                  h_lim  <= image_height - dimdata_size'(kernel_size);
                  w_lim  <= image_width - dimdata_size'(kernel_size);
                  k      <= kernel_size;
                  offset <= fifo_offset;
                  r      <= '0;
                  c      <= '0;
                  ky     <= '0;
                  kx     <= '0;
                  lane   <= LW'(fifo_offset);
                  if (degenerate) begin
                     state <= DONE;
                  end else begin
                     // Read for tap 0 is launched on entry so ISSUE itself carries mem_en.
                     state    <= ISSUE;
                     busy     <= 1'b1;
                     mem_en   <= (LW'(fifo_offset) < LANES);
                     mem_addr <= initial_address;
                  end
               end
            end
            ISSUE: begin
               if (lane_ok) begin
                  mem_en <= 1'b0;
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               fifo_w_data <= mem_rdata;
               state       <= PUSH;
            end
            PUSH: ;
            DONE: begin
               fill_done <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // Step to the next tap after a push or a skipped (out-of-range lane) tap.
         if (advance) begin
            r    <= nxt_r;
            c    <= nxt_c;
            ky   <= nxt_ky;
            kx   <= nxt_kx;
            lane <= nxt_lane;
            if (last_tap) begin
               state  <= DONE;
               busy   <= 1'b0;
               mem_en <= 1'b0;
            end else begin
               state    <= ISSUE;
               mem_en   <= (nxt_lane < LANES);
               mem_addr <= nxt_addr;
            end
         end
      end
   end

endmodule
